// File: rtl/mem_dma_pkg.sv
// Shared types and constants for the mem_dma copy engine.
// Overlap-safe descending copies are enabled by defining MEM_DMA_OVERLAP_EN.
package mem_dma_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_READ,
    S_WAIT,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  // Words at or above SEG_LIMIT are never legal copy targets or sources.
  localparam int unsigned SEG_LIMIT = 1568;
  localparam int unsigned SEG_BASE0 = 0;
  localparam int unsigned SEG_BASE1 = 32;
  localparam int unsigned SEG_BASE2 = 1056;

endpackage

// File: rtl/mem_dma_range.sv
// Combinational range/overlap qualification for a latched copy request.
// The overlap flag is only produced when MEM_DMA_OVERLAP_EN is defined.
module mem_dma_range import mem_dma_pkg::*; #(
  parameter int WIDTH   = 32,
  parameter int RAMSIZE = 1024
) (
  input  logic [WIDTH-1:0] src,
  input  logic [WIDTH-1:0] dst,
  input  logic [WIDTH-1:0] len,
  output logic             range_err,
  output logic             overlap
);

  localparam logic [WIDTH:0] LIMIT   = (WIDTH+1)'(SEG_LIMIT);
  localparam logic [WIDTH:0] IO_ADDR = (WIDTH+1)'(RAMSIZE * 7);

  logic [WIDTH:0] src_end;
  logic [WIDTH:0] dst_end;

  always_comb begin
    // One extra bit so a wrapping end address still compares as out of range.
    src_end   = {1'b0, src} + {1'b0, len};
    dst_end   = {1'b0, dst} + {1'b0, len};
    range_err = (src_end > LIMIT) || (dst_end > LIMIT) ||
                ((len != '0) && ({1'b0, dst} <= IO_ADDR) && (IO_ADDR < dst_end));
`ifdef MEM_DMA_OVERLAP_EN
    overlap   = (src < dst) && ({1'b0, dst} < src_end);
`else
    overlap   = 1'b0;
`endif
  end

endmodule

// File: rtl/mem_dma.sv
// Word-copy DMA engine: READ/WAIT/WRITE per word over a shared memory data port.
// Define MEM_DMA_OVERLAP_EN to copy overlapping forward regions in descending order.
module mem_dma import mem_dma_pkg::*; #(
  parameter int WIDTH   = 32,
  parameter int RAMSIZE = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] src,
  input  logic [WIDTH-1:0] dst,
  input  logic [WIDTH-1:0] len,
  input  logic             gnt,
  output logic             req,
  output logic [WIDTH-1:0] memA,
  output logic [WIDTH-1:0] memWd,
  output logic             memWe,
  input  logic [WIDTH-1:0] memRd,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state;
  logic [WIDTH-1:0] src_q, dst_q, len_q, idx, data;
  logic             desc, we_q;
  logic             range_err, overlap;

  mem_dma_range #(.WIDTH(WIDTH), .RAMSIZE(RAMSIZE)) u_range (
    .src      (src_q),
    .dst      (dst_q),
    .len      (len_q),
    .range_err(range_err),
    .overlap  (overlap)
  );

  function automatic logic [WIDTH-1:0] offset(input logic [WIDTH-1:0] i,
                                              input logic [WIDTH-1:0] n,
                                              input logic             d);
    offset = d ? (n - i - ONE) : i;
  endfunction

  assign memWd = data;
  // Write strobe follows gnt in the same cycle; reset suppresses the write on its edge.
  assign memWe = we_q & gnt & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      src_q <= '0;
      dst_q <= '0;
      len_q <= '0;
      idx   <= '0;
      data  <= '0;
      desc  <= 1'b0;
      we_q  <= 1'b0;
      req   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      memA  <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          src_q <= src;
          dst_q <= dst;
          len_q <= len;
          idx   <= '0;
          busy  <= 1'b1;
          state <= S_CHECK;
        end
        S_CHECK: begin
          if (range_err) begin
            err   <= 1'b1;
            state <= S_ERR;
          end else if (len_q == '0) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            desc  <= overlap;
            req   <= 1'b1;
            memA  <= src_q + offset('0, len_q, overlap);
            state <= S_READ;
          end
        end
        S_READ: if (gnt) state <= S_WAIT;
        S_WAIT: begin
          data  <= memRd;
          we_q  <= 1'b1;
          memA  <= dst_q + offset(idx, len_q, desc);
          state <= S_WRITE;
        end
        S_WRITE: if (gnt) begin
          idx  <= idx + ONE;
          we_q <= 1'b0;
          if (idx + ONE == len_q) begin
            req   <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            memA  <= src_q + offset(idx + ONE, len_q, desc);
            state <= S_READ;
          end
        end
        S_DONE, S_ERR: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dma.sv
// Scoreboard bench for mem_dma: a reference copy model feeds expected writes and
// completions into queues that a negedge monitor drains as the DUT produces them.
module tb_mem_dma;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        gnt = 1'b1;
  logic [31:0] src = '0, dst = '0, len = '0;
  logic [31:0] memA, memWd;
  logic [31:0] memRd = '0;
  logic        req, memWe, busy, done, err;

  mem_dma #(.WIDTH(32), .RAMSIZE(1024)) dut (
    .clk(clk), .reset(reset), .start(start), .src(src), .dst(dst), .len(len),
    .gnt(gnt), .req(req), .memA(memA), .memWd(memWd), .memWe(memWe),
    .memRd(memRd), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  logic [31:0] mem     [0:2047];
  logic [31:0] ref_mem [0:2047];
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    memRd <= (memA < 2048) ? mem[memA[10:0]] : '0;
    if (memWe && memA < 2048) mem[memA[10:0]] <= memWd;
  end

  typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
  typedef struct { bit is_err; bit timed; int t_exp; int busy_exp; } cmp_t;

  wr_t  wq[$];
  cmp_t cq[$];
  int   checks = 0;
  int   errors = 0;
  bit   stall_chk = 1'b0;
  int   busy_cnt = 0;
  bit   prev_done = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT writes or completes.
  always @(negedge clk) begin
    wr_t  w;
    cmp_t c;
    if (reset) begin
      busy_cnt  = 0;
      prev_done = 1'b0;
    end else begin
      if (stall_chk) chk("stall_we", longint'(memWe), 0);
      if (memWe) begin
        chk("wr_addr_range", longint'(memA < 1568), 1);
        if (wq.size() == 0) chk("unexpected_write", longint'(memA), -1);
        else begin
          w = wq.pop_front();
          chk("wr_addr", memA, w.a);
          chk("wr_data", memWd, w.d);
        end
      end
      if (busy && !done && !err) busy_cnt++;
      if (done) chk("done_pulse", longint'(prev_done), 0);
      if (done || err) begin
        if (cq.size() == 0) chk("unexpected_end", longint'(err), -1);
        else begin
          c = cq.pop_front();
          chk("end_is_err", longint'(err), longint'(c.is_err));
          chk("end_is_done", longint'(done), longint'(!c.is_err));
          if (c.timed) begin
            chk("latency", cyc, c.t_exp);
            chk("busy_cycles", busy_cnt, c.busy_exp);
          end
          if (!c.is_err) chk("writes_left_at_done", wq.size(), 0);
        end
        busy_cnt = 0;
      end
      prev_done = done;
    end
  end

  // Reference model: plain word copy on ref_mem, expectations pushed in order.
  task automatic model(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l,
                       input bit timed, input int t0, input int stall);
    cmp_t c;
    wr_t  w;
    bit   desc;
    c.timed  = timed;
    c.is_err = 1'b0;
    if (longint'(s) + longint'(l) > 1568 || longint'(d) + longint'(l) > 1568) begin
      c.is_err   = 1'b1;
      c.t_exp    = t0 + 2;
      c.busy_exp = 1;
    end else begin
      desc = 1'b0;
`ifdef MEM_DMA_OVERLAP_EN
      desc = (s < d) && (longint'(d) < longint'(s) + longint'(l));
`endif
      for (int k = 0; k < int'(l); k++) begin
        int i;
        i = desc ? int'(l) - 1 - k : k;
        ref_mem[d + i] = ref_mem[s + i];
        w.a = d + i;
        w.d = ref_mem[d + i];
        wq.push_back(w);
      end
      c.t_exp    = t0 + 3 * int'(l) + 2 + stall;
      c.busy_exp = 3 * int'(l) + 1 + stall;
    end
    cq.push_back(c);
  endtask

  // mode 0: gnt high, timed, stray start mid-copy; 1: random gnt; 2: 5-cycle stall in WRITE of word 1
  task automatic xfer(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l,
                      input int mode);
    int t0;
    int n;
    @(posedge clk); #1;
    t0 = cyc;
    model(s, d, l, mode != 1, t0, (mode == 2) ? 5 : 0);
    src = s; dst = d; len = l; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    src = $urandom; dst = $urandom; len = $urandom;
    n = 0;
    while ((wq.size() != 0 || cq.size() != 0 || busy) && n < 2000) begin
      case (mode)
        1:       gnt = ($urandom % 3) != 0;
        2:       gnt = !(cyc >= t0 + 7 && cyc < t0 + 12);
        default: gnt = 1'b1;
      endcase
      start = (mode == 0) && (cyc == t0 + 4);
      stall_chk = !gnt;
      @(posedge clk); #1;
      n++;
    end
    gnt = 1'b1; start = 1'b0; stall_chk = 1'b0;
    if (n >= 2000) begin
      chk("xfer_timeout", n, 0);
      wq.delete();
      cq.delete();
    end
  endtask

  initial begin
    logic [31:0] orig [0:3];
    int t0;
    int bad;
    for (int i = 0; i < 2048; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req", req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_we", memWe, 0);
    chk("rst_memA", memA, 0);
    chk("rst_memWd", memWd, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    xfer(40, 1100, 4, 0);
    xfer(500, 600, 0, 0);
    xfer(0, 1565, 4, 0);
    xfer(0, 32'hFFFF_FFFF, 2, 0);
    xfer(1560, 1564, 4, 0);
    xfer(10, 20, 4, 2);

    for (int k = 0; k < 4; k++) orig[k] = ref_mem[100 + k];
    xfer(100, 102, 4, 0);
`ifdef MEM_DMA_OVERLAP_EN
    for (int k = 0; k < 4; k++) chk("overlap_desc", mem[102 + k], orig[k]);
`else
    chk("overlap_asc_102", mem[102], orig[0]);
    chk("overlap_asc_103", mem[103], orig[1]);
    chk("overlap_asc_104", mem[104], orig[0]);
    chk("overlap_asc_105", mem[105], orig[1]);
`endif

    // Reset during the WRITE of word 1: only word 0 may land.
    @(posedge clk); #1;
    t0 = cyc;
    ref_mem[300] = ref_mem[200];
    wq.push_back('{a: 32'd300, d: ref_mem[200]});
    src = 200; dst = 300; len = 4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < t0 + 7) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(negedge clk);
    chk("reset_we_gated", memWe, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst2_req", req, 0);
    chk("rst2_busy", busy, 0);
    chk("rst2_done", done, 0);
    chk("rst2_err", err, 0);
    chk("rst2_we", memWe, 0);
    chk("rst2_memA", memA, 0);
    chk("rst2_memWd", memWd, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("reset_pending_writes", wq.size(), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("idle_after_reset", busy, 0);

    repeat (40) begin
      logic [31:0] s, d, l;
      s = $urandom_range(0, 1580);
      d = ($urandom % 3 == 0) ? s + $urandom_range(0, 6) : $urandom_range(0, 1580);
      l = $urandom_range(0, 8);
      xfer(s, d, l, int'($urandom % 2));
    end

    bad = 0;
    for (int i = 0; i < 2048; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk("final_mem_mismatches", bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
